// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding, parity
// mode constants and the parity-check helper.
package serial_pkg;

    // Receiver frame states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_DELIVER   = 3'd5,
        ST_WAIT_HIGH = 3'd6
    } rx_state_e;

    // Parity modes selected by the PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Returns 1 when the data XOR plus the received parity bit disagree
    // with the selected mode. Even mode expects an even count of ones
    // across data and parity; odd mode expects an odd count.
    function automatic logic parity_error(input logic data_xor,
                                          input logic par_bit,
                                          input int   mode);
        logic ones_odd;
        ones_odd = data_xor ^ par_bit;
        case (mode)
            PAR_EVEN: return ones_odd;
            PAR_ODD:  return ~ones_odd;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/serial_baud_gen.sv
// Sample-tick generator: one tick every div+1 clk cycles while enabled.
// The counter sits at zero while disabled and restarts on request, so the
// first tick after a restart lands exactly div+1 cycles later.
module serial_baud_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == div);
    assign tick   = en && !restart && w_wrap;

    // Free-running divisor counter, cleared when idle or restarted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!en || restart) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/serial_rx_cfg.sv
// Configurable oversampling serial receiver with parity, framing and break
// detection, a valid/ready output handshake and a sticky overrun flag.
module serial_rx_cfg
    import serial_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 4,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 rxserialin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_break,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    input  logic                 clr_ovr
);

    localparam int TCW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BCW = $clog2(DATA_BITS + 1);

    localparam logic [TCW-1:0] HALF_M1 = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] FULL_M1 = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] DATA_M1 = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_M1 = BCW'(STOP_BITS - 1);

    // Synchroniser and edge detection.
    logic r_sync1;
    logic r_sync2;
    logic r_rx_prev;
    logic w_rx;
    logic w_start_edge;

    // Frame engine state.
    rx_state_e            r_state;
    logic [DIV_W-1:0]     r_div;
    logic [TCW-1:0]       r_tcnt;
    logic [BCW-1:0]       r_bcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_all_zero;

    // Tick generation.
    logic w_baud_en;
    logic w_tick;
    logic w_sample_start;
    logic w_sample_bit;

    assign w_rx         = r_sync2;
    assign w_start_edge = r_rx_prev && !w_rx;

    assign w_baud_en = (r_state == ST_START)  || (r_state == ST_DATA) ||
                       (r_state == ST_PARITY) || (r_state == ST_STOP);

    // Start bit is sampled half a bit in; every later bit a full bit on.
    assign w_sample_start = w_tick && (r_tcnt == HALF_M1);
    assign w_sample_bit   = w_tick && (r_tcnt == FULL_M1);

    serial_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (w_baud_en),
        .restart (w_start_edge && (r_state == ST_IDLE)),
        .div     (r_div),
        .tick    (w_tick)
    );

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    // NOTE: these reset to 1 (idle line level) so reset release can never
    // look like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make this a true shift chain;
            // blocking ones would collapse it into a single flop.
            r_sync1   <= rxserialin;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Frame FSM with its datapath and the registered output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_tcnt     <= '0;
            r_bcnt     <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_all_zero <= 1'b0;
            rx_data    <= '0;
            rx_perr    <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_break   <= 1'b0;
            rx_valid   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // NOTE: these are defaults; a later assignment to the same
            // register in the DELIVER branch below overrides them, which is
            // how a same-cycle overrun wins over clr_ovr.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (clr_ovr) begin
                overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_tcnt <= '0;
                    r_bcnt <= '0;
                    if (w_start_edge) begin
                        r_div   <= baud_div;
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_sample_start) begin
                        r_tcnt <= '0;
                        if (w_rx) begin
                            // Line went back high: glitch, not a frame.
                            r_state <= ST_IDLE;
                        end else begin
                            r_bcnt     <= '0;
                            r_perr     <= 1'b0;
                            r_ferr     <= 1'b0;
                            r_all_zero <= 1'b1;
                            r_state    <= ST_DATA;
                        end
                    end else if (w_tick) begin
                        r_tcnt <= r_tcnt + TCW'(1);
                    end
                end

                ST_DATA: begin
                    if (w_sample_bit) begin
                        r_tcnt     <= '0;
                        r_shift    <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_all_zero <= r_all_zero && !w_rx;
                        if (r_bcnt == DATA_M1) begin
                            r_bcnt  <= '0;
                            r_state <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            r_bcnt <= r_bcnt + BCW'(1);
                        end
                    end else if (w_tick) begin
                        r_tcnt <= r_tcnt + TCW'(1);
                    end
                end

                ST_PARITY: begin
                    if (w_sample_bit) begin
                        r_tcnt     <= '0;
                        r_perr     <= parity_error(^r_shift, w_rx, PARITY);
                        r_all_zero <= r_all_zero && !w_rx;
                        r_state    <= ST_STOP;
                    end else if (w_tick) begin
                        r_tcnt <= r_tcnt + TCW'(1);
                    end
                end

                ST_STOP: begin
                    if (w_sample_bit) begin
                        r_tcnt     <= '0;
                        r_all_zero <= r_all_zero && !w_rx;
                        if (!w_rx) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_bcnt == STOP_M1) begin
                            r_bcnt  <= '0;
                            r_state <= ST_DELIVER;
                        end else begin
                            r_bcnt <= r_bcnt + BCW'(1);
                        end
                    end else if (w_tick) begin
                        r_tcnt <= r_tcnt + TCW'(1);
                    end
                end

                ST_DELIVER: begin
                    if (!rx_valid || rx_ready) begin
                        rx_data  <= r_shift;
                        rx_perr  <= r_perr;
                        rx_ferr  <= r_ferr;
                        rx_break <= r_all_zero;
                        rx_valid <= 1'b1;
                    end else begin
                        // Previous word still unread: drop the new one.
                        overrun <= 1'b1;
                    end
                    r_state <= w_rx ? ST_IDLE : ST_WAIT_HIGH;
                end

                ST_WAIT_HIGH: begin
                    // Held low (break or bad stop): re-arm only once high.
                    if (w_rx) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_cfg.sv
// Bench for serial_rx_cfg: two receivers (8N1 and 8E2) fed by directed
// frames. A frame-level model predicts, from the bits sent, when each word
// must appear and with which flags; every cycle the outputs are compared.
`timescale 1ns/1ps
module tb_serial_rx_cfg;

    localparam int NCH = 2;
    localparam int OS  = 4;
    localparam int DIV = 9;
    localparam int P   = (DIV + 1) * OS;   // clk cycles per bit
    localparam int DB  = 8;

    typedef struct {
        int         at;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] div    [NCH];
    logic       line   [NCH];
    logic       ready  [NCH];
    logic       clr    [NCH];
    logic [7:0] rx_data  [NCH];
    logic       rx_perr  [NCH];
    logic       rx_ferr  [NCH];
    logic       rx_break [NCH];
    logic       rx_valid [NCH];
    logic       ovr      [NCH];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state.
    word_t      pend0[$];
    word_t      pend1[$];
    logic       m_valid [NCH] = '{1'b0, 1'b0};
    logic [7:0] m_data  [NCH] = '{8'h00, 8'h00};
    logic       m_perr  [NCH] = '{1'b0, 1'b0};
    logic       m_ferr  [NCH] = '{1'b0, 1'b0};
    logic       m_brk   [NCH] = '{1'b0, 1'b0};
    logic       m_ovr   [NCH] = '{1'b0, 1'b0};

    // Rising-edge capture of rx_valid for the literal checks.
    logic       prev_valid [NCH] = '{1'b0, 1'b0};
    int         rise_cyc   [NCH] = '{-1, -1};
    logic [7:0] rise_data  [NCH];
    logic       rise_perr  [NCH];
    logic       rise_ferr  [NCH];
    logic       rise_brk   [NCH];

    always #5 clk = ~clk;

    serial_rx_cfg #(
        .DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1), .DIV_W(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .baud_div(div[0]), .rxserialin(line[0]),
        .rx_data(rx_data[0]), .rx_perr(rx_perr[0]), .rx_ferr(rx_ferr[0]),
        .rx_break(rx_break[0]), .rx_valid(rx_valid[0]), .rx_ready(ready[0]),
        .overrun(ovr[0]), .clr_ovr(clr[0])
    );

    serial_rx_cfg #(
        .DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(2), .DIV_W(8)
    ) u_dut_par (
        .clk(clk), .rst_n(rst_n), .baud_div(div[1]), .rxserialin(line[1]),
        .rx_data(rx_data[1]), .rx_perr(rx_perr[1]), .rx_ferr(rx_ferr[1]),
        .rx_break(rx_break[1]), .rx_valid(rx_valid[1]), .rx_ready(ready[1]),
        .overrun(ovr[1]), .clr_ovr(clr[1])
    );

    function automatic int n_par(input int ch);
        return (ch == 0) ? 0 : 1;
    endfunction

    function automatic int n_stop(input int ch);
        return (ch == 0) ? 1 : 2;
    endfunction

    // Cycles from driving the start edge to the edge that loads the word:
    // 2 synchroniser flops + 1 detect cycle, then the sample ticks up to the
    // last stop bit, then the DELIVER cycle.
    function automatic int load_delay(input int ch);
        return 4 + (DIV + 1) * (OS / 2 + OS * (DB + n_par(ch) + n_stop(ch)));
    endfunction

    task automatic check(input string name, input int ch,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s ch%0d cyc=%0d: got %0h want %0h", name, ch, cyc, act, exp);
        end
    endtask

    // Model: apply scheduled word arrivals and the handshake at each edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                word_t w;
                bit    ev;
                bit    ovr_ev;
                ev = 1'b0;
                ovr_ev = 1'b0;
                if (ch == 0 && pend0.size() > 0 && pend0[0].at == cyc) begin
                    w = pend0.pop_front();
                    ev = 1'b1;
                end
                if (ch == 1 && pend1.size() > 0 && pend1[0].at == cyc) begin
                    w = pend1.pop_front();
                    ev = 1'b1;
                end
                if (ev) begin
                    if (!m_valid[ch] || ready[ch]) begin
                        m_valid[ch] = 1'b1;
                        m_data[ch]  = w.data;
                        m_perr[ch]  = w.perr;
                        m_ferr[ch]  = w.ferr;
                        m_brk[ch]   = w.brk;
                    end else begin
                        ovr_ev = 1'b1;
                    end
                end else if (m_valid[ch] && ready[ch]) begin
                    m_valid[ch] = 1'b0;
                end
                if (ovr_ev) m_ovr[ch] = 1'b1;
                else if (clr[ch]) m_ovr[ch] = 1'b0;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            check("rx_valid", ch, 32'(rx_valid[ch]), 32'(m_valid[ch]));
            check("rx_data",  ch, 32'(rx_data[ch]),  32'(m_data[ch]));
            check("rx_perr",  ch, 32'(rx_perr[ch]),  32'(m_perr[ch]));
            check("rx_ferr",  ch, 32'(rx_ferr[ch]),  32'(m_ferr[ch]));
            check("rx_break", ch, 32'(rx_break[ch]), 32'(m_brk[ch]));
            check("overrun",  ch, 32'(ovr[ch]),      32'(m_ovr[ch]));
            if (rx_valid[ch] && !prev_valid[ch]) begin
                rise_cyc[ch]  = cyc;
                rise_data[ch] = rx_data[ch];
                rise_perr[ch] = rx_perr[ch];
                rise_ferr[ch] = rx_ferr[ch];
                rise_brk[ch]  = rx_break[ch];
            end
            prev_valid[ch] = rx_valid[ch];
        end
    end

    task automatic expect_word(input int ch, input int c0, input logic [7:0] data,
                               input logic par, input logic [1:0] stops);
        word_t w;
        logic  zero;
        w.at   = c0 + load_delay(ch);
        w.data = data;
        w.perr = (n_par(ch) != 0) ? ((^data) ^ par) : 1'b0;   // even parity
        w.ferr = 1'b0;
        zero   = (data == 8'h00) && (n_par(ch) == 0 || par == 1'b0);
        for (int s = 0; s < n_stop(ch); s++) begin
            if (!stops[s]) w.ferr = 1'b1;
            if (stops[s]) zero = 1'b0;
        end
        w.brk = zero;
        if (ch == 0) pend0.push_back(w);
        else pend1.push_back(w);
    endtask

    // Called at a negedge; holds the level for n cycles, ends at a negedge.
    task automatic drive(input int ch, input logic b, input int n);
        line[ch] = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int ch, input logic [7:0] data, input logic par,
                              input logic [1:0] stops, input int idle_bits,
                              input bit wiggle_div, output int c0);
        c0 = cyc;
        rise_cyc[ch] = -1;
        expect_word(ch, c0, data, par, stops);
        drive(ch, 1'b0, P);
        if (wiggle_div) div[ch] = 8'd3;
        for (int i = 0; i < DB; i++) drive(ch, data[i], P);
        if (n_par(ch) != 0) drive(ch, par, P);
        for (int s = 0; s < n_stop(ch); s++) drive(ch, stops[s], P);
        div[ch] = 8'(DIV);
        drive(ch, 1'b1, idle_bits * P);
    endtask

    task automatic check_rise(input int ch, input int c0, input int lat,
                              input logic [7:0] data, input logic perr,
                              input logic ferr, input logic brk);
        check("latency",   ch, 32'(rise_cyc[ch] - c0), 32'(lat));
        check("word",      ch, 32'(rise_data[ch]),     32'(data));
        check("word_perr", ch, 32'(rise_perr[ch]),     32'(perr));
        check("word_ferr", ch, 32'(rise_ferr[ch]),     32'(ferr));
        check("word_brk",  ch, 32'(rise_brk[ch]),      32'(brk));
    endtask

    initial begin
        int c0;
        for (int ch = 0; ch < NCH; ch++) begin
            div[ch] = 8'(DIV);
            line[ch] = 1'b1;
            ready[ch] = 1'b1;
            clr[ch] = 1'b0;
        end
        #1;
        check("reset_valid", 0, 32'(rx_valid[0]), 32'h0);
        check("reset_data",  0, 32'(rx_data[0]),  32'h0);
        check("reset_ovr",   0, 32'(ovr[0]),      32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xA5: word loaded 384 clk after the start edge is driven.
        send_frame(0, 8'hA5, 1'b0, 2'b11, 2, 1'b0, c0);
        check_rise(0, c0, 384, 8'hA5, 1'b0, 1'b0, 1'b0);

        // 8E2 0x07 (three ones): parity bit 0 is wrong, 1 is right.
        send_frame(1, 8'h07, 1'b0, 2'b11, 2, 1'b0, c0);
        check_rise(1, c0, 464, 8'h07, 1'b1, 1'b0, 1'b0);
        send_frame(1, 8'h07, 1'b1, 2'b11, 2, 1'b0, c0);
        check_rise(1, c0, 464, 8'h07, 1'b0, 1'b0, 1'b0);
        // Second stop bit low: framing error on the two-stop receiver.
        send_frame(1, 8'h81, 1'b0, 2'b01, 2, 1'b0, c0);
        check_rise(1, c0, 464, 8'h81, 1'b0, 1'b1, 1'b0);

        // Break: line low for 12 bit times.
        c0 = cyc;
        rise_cyc[0] = -1;
        expect_word(0, c0, 8'h00, 1'b0, 2'b00);
        drive(0, 1'b0, 12 * P);
        drive(0, 1'b1, 2 * P);
        check_rise(0, c0, 384, 8'h00, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'h96, 1'b0, 2'b11, 2, 1'b0, c0);
        check_rise(0, c0, 384, 8'h96, 1'b0, 1'b0, 1'b0);

        // 10-clk glitch: no word; then a frame with a low stop bit.
        drive(0, 1'b0, 10);
        drive(0, 1'b1, 3 * P);
        send_frame(0, 8'h5A, 1'b0, 2'b10, 2, 1'b0, c0);
        check_rise(0, c0, 384, 8'h5A, 1'b0, 1'b1, 1'b0);

        // Divisor changed mid-frame must not disturb the frame in flight.
        send_frame(0, 8'hC3, 1'b0, 2'b11, 2, 1'b1, c0);
        check_rise(0, c0, 384, 8'hC3, 1'b0, 1'b0, 1'b0);

        // Overrun: consumer stalled across two frames.
        ready[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 2'b11, 1, 1'b0, c0);
        send_frame(0, 8'h22, 1'b0, 2'b11, 1, 1'b0, c0);
        check("ovr_data", 0, 32'(rx_data[0]), 32'h11);
        check("ovr_set",  0, 32'(ovr[0]),     32'h1);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        @(negedge clk);
        check("ovr_clr", 0, 32'(ovr[0]), 32'h0);

        // clr_ovr during the overrun cycle itself: overrun must stay set.
        fork
            send_frame(0, 8'h33, 1'b0, 2'b11, 1, 1'b0, c0);
            begin
                repeat (383) @(negedge clk);
                clr[0] = 1'b1;
                @(negedge clk);
                clr[0] = 1'b0;
            end
        join
        check("ovr_race", 0, 32'(ovr[0]), 32'h1);
        check("ovr_keep", 0, 32'(rx_data[0]), 32'h11);
        ready[0] = 1'b1;
        repeat (3) @(negedge clk);

        // Reset in the middle of the data bits.
        send_frame(0, 8'h44, 1'b0, 2'b11, 1, 1'b0, c0);
        drive(0, 1'b0, P);
        drive(0, 1'b1, P);
        drive(0, 1'b0, P);
        drive(0, 1'b1, P / 2);
        #2;
        rst_n = 1'b0;
        line[0] = 1'b1;
        pend0.delete();
        pend1.delete();
        for (int ch = 0; ch < NCH; ch++) begin
            m_valid[ch] = 1'b0;
            m_data[ch]  = 8'h00;
            m_perr[ch]  = 1'b0;
            m_ferr[ch]  = 1'b0;
            m_brk[ch]   = 1'b0;
            m_ovr[ch]   = 1'b0;
        end
        #1;
        check("rst_data", 0, 32'(rx_data[0]),  32'h0);
        check("rst_ovr",  0, 32'(ovr[0]),      32'h0);
        check("rst_valid", 0, 32'(rx_valid[0]), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (P) @(negedge clk);
        send_frame(0, 8'h3C, 1'b0, 2'b11, 2, 1'b0, c0);
        check_rise(0, c0, 384, 8'h3C, 1'b0, 1'b0, 1'b0);

        check("pending0", 0, 32'(pend0.size()), 32'h0);
        check("pending1", 1, 32'(pend1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
